axi4_slave_write_responder: RTL and testbench

AXI4_SLAVE_WRITE_RESPONDER -- requirements
Module: axi4_slave_write_responder

---
 rtl/axi4_globals_pkg.sv | 12 +
 rtl/axi4_slave_write_responder_if.sv | 26 ++
 rtl/axi4_slave_byte_mem.sv | 19 +
 rtl/axi4_slave_write_responder.sv | 113 +++++++++++
 tb/tb_axi4_slave_write_responder.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_globals_pkg.sv
// axi4_globals_pkg: shared AXI4 widths, burst/size/response encodings and FSM states.
package axi4_globals_pkg;
    localparam int ADDRESS_WIDTH = 16;
    localparam int DATA_WIDTH = 32;
    localparam int LENGTH = 8;
    localparam int MEM_BYTES = 4096;
    localparam int BOUNDARY_4KB = 4096;
    typedef enum logic [1:0] {BURST_FIXED, BURST_INCR, BURST_WRAP, BURST_RSVD} awburst_e;
    typedef enum logic [2:0] {SIZE_1B, SIZE_2B, SIZE_4B, SIZE_8B, SIZE_16B, SIZE_32B, SIZE_64B, SIZE_128B} awsize_e;
    typedef enum logic [1:0] {RESP_OKAY, RESP_EXOKAY, RESP_SLVERR, RESP_DECERR} bresp_e;
    typedef enum logic [1:0] {IDLE, DATA, RESP, WAIT} state_e;
endpackage

// File: rtl/axi4_slave_write_responder_if.sv
// axi4_slave_write_responder_if: AXI4 write address, data and response channels.
interface axi4_slave_write_responder_if #(
    parameter int ADDRESS_WIDTH = axi4_globals_pkg::ADDRESS_WIDTH,
    parameter int DATA_WIDTH = axi4_globals_pkg::DATA_WIDTH
);
    logic [15:0] awid;
    logic [ADDRESS_WIDTH-1:0] awaddr;
    logic [axi4_globals_pkg::LENGTH-1:0] awlen;
    logic [2:0] awsize;
    logic [1:0] awburst;
    logic awvalid, awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic wlast, wvalid, wready;
    logic [15:0] bid;
    logic [1:0] bresp;
    logic bvalid, bready;
    modport slave (
        input awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
        output awready, wready, bid, bresp, bvalid
    );
    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
        input awready, wready, bid, bresp, bvalid
    );
endinterface

// File: rtl/axi4_slave_byte_mem.sv
// axi4_slave_byte_mem: byte-lane strobed write port plus asynchronous byte read port.
module axi4_slave_byte_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_BYTES = 4096
) (
    input  logic                         clk,
    input  logic [DATA_WIDTH/8-1:0]      we,
    input  logic [$clog2(MEM_BYTES)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic [$clog2(MEM_BYTES)-1:0] raddr,
    output logic [7:0]                   rdata
);
    localparam int MA = $clog2(MEM_BYTES);
    logic [7:0] mem [MEM_BYTES];
    always_ff @(posedge clk)
        for (int i = 0; i < DATA_WIDTH / 8; i++)
            if (we[i]) mem[waddr + MA'(i)] <= wdata[8*i +: 8];
    assign rdata = mem[raddr];
endmodule

// File: rtl/axi4_slave_write_responder.sv
// axi4_slave_write_responder: single-outstanding AXI4 write slave over a byte-strobed memory.
// Define AXI4_SLV_BRESP_DELAY_EN to add the bdelay port and a WAIT state before the response.
module axi4_slave_write_responder
    import axi4_globals_pkg::*;
#(
    parameter int ADDRESS_WIDTH = axi4_globals_pkg::ADDRESS_WIDTH,
    parameter int DATA_WIDTH = axi4_globals_pkg::DATA_WIDTH,
    parameter int MEM_BYTES = axi4_globals_pkg::MEM_BYTES
) (
    input  logic                         aclk,
    input  logic                         areset,
`ifdef AXI4_SLV_BRESP_DELAY_EN
    input  logic [3:0]                   bdelay,
`endif
    axi4_slave_write_responder_if.slave  bus,
    input  logic [$clog2(MEM_BYTES)-1:0] test_addr,
    output logic [7:0]                   test_data
);
    localparam int DB = DATA_WIDTH / 8;
    localparam int MA = $clog2(MEM_BYTES);
    state_e state, state_n, done_state;
    logic [15:0] id_q;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_n, step;
    logic [LENGTH-1:0] len_q, cnt;
    awsize_e size_q;
    awburst_e burst_q;
    logic over, dec, slv, cfg_bad, in_range, aw_hs, w_hs, aw_bad;
    logic [31:0] sz32, start32, last32;
    logic [DB-1:0] we;
`ifdef AXI4_SLV_BRESP_DELAY_EN
    logic [3:0] dcnt;
    assign done_state = bdelay == 4'd0 ? RESP : WAIT;
`else
    assign done_state = RESP;
`endif
    assign bus.awready = ~areset & (state == IDLE);
    assign bus.wready = ~areset & (state == DATA);
    assign bus.bvalid = ~areset & (state == RESP);
    assign bus.bid = areset ? '0 : id_q;
    assign bus.bresp = areset ? RESP_OKAY : dec ? RESP_DECERR : slv ? RESP_SLVERR : RESP_OKAY;
    assign aw_hs = bus.awvalid & bus.awready;
    assign w_hs = bus.wvalid & bus.wready;
    // Declared INCR footprint is checked against the 4KB page up front.
    assign sz32 = 32'd1 << bus.awsize;
    assign start32 = 32'(bus.awaddr);
    assign last32 = (start32 & ~(sz32 - 32'd1)) + (32'(bus.awlen) << bus.awsize);
    assign aw_bad = bus.awburst[1] | (sz32 > DB)
                  | (bus.awburst == BURST_INCR && start32 / BOUNDARY_4KB != last32 / BOUNDARY_4KB);
    assign cfg_bad = burst_q[1] | ((32'd1 << size_q) > DB);
    assign step = ADDRESS_WIDTH'(1) << size_q;
    assign addr_n = burst_q == BURST_INCR ? (addr_q & ~(step - 1'b1)) + step : addr_q;
    assign in_range = 32'(addr_q) < MEM_BYTES;
    assign we = (w_hs & in_range & ~over & ~cfg_bad) ? bus.wstrb : '0;
    always_ff @(posedge aclk) state <= areset ? IDLE : state_n;
    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = aw_hs ? DATA : IDLE;
            DATA: state_n = (w_hs & bus.wlast) ? done_state : DATA;
`ifdef AXI4_SLV_BRESP_DELAY_EN
            WAIT: state_n = dcnt == 4'd1 ? RESP : WAIT;
`endif
            RESP: state_n = bus.bready ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end
    // over marks beats past awlen+1: accepted, never written, always SLVERR.
    always_ff @(posedge aclk) begin
        if (areset) begin
            id_q <= '0;
            addr_q <= '0;
            len_q <= '0;
            size_q <= SIZE_1B;
            burst_q <= BURST_FIXED;
            cnt <= '0;
            over <= 1'b0;
            dec <= 1'b0;
            slv <= 1'b0;
`ifdef AXI4_SLV_BRESP_DELAY_EN
            dcnt <= '0;
`endif
        end else if (aw_hs) begin
            id_q <= bus.awid;
            addr_q <= bus.awaddr;
            len_q <= bus.awlen;
            size_q <= awsize_e'(bus.awsize);
            burst_q <= awburst_e'(bus.awburst);
            cnt <= '0;
            over <= 1'b0;
            dec <= 1'b0;
            slv <= aw_bad;
        end else if (w_hs) begin
            addr_q <= addr_n;
            cnt <= cnt + 1'b1;
            over <= over | (cnt == len_q);
            dec <= dec | (~over & ~in_range);
            slv <= slv | over | (bus.wlast & (cnt != len_q));
`ifdef AXI4_SLV_BRESP_DELAY_EN
            if (bus.wlast) dcnt <= bdelay;
        end else if (state == WAIT) begin
            dcnt <= dcnt - 1'b1;
`endif
        end
    end
    axi4_slave_byte_mem #(.DATA_WIDTH(DATA_WIDTH), .MEM_BYTES(MEM_BYTES)) u_mem (
        .clk(aclk),
        .we(we),
        .waddr(MA'(addr_q) & ~MA'(DB - 1)),
        .wdata(bus.wdata),
        .raddr(test_addr),
        .rdata(test_data)
    );
endmodule

// File: tb/tb_axi4_slave_write_responder.sv
// tb_axi4_slave_write_responder: vector table, directed corner sequences and randomized bursts vs a byte-level model.
module tb_axi4_slave_write_responder;
    import axi4_globals_pkg::*;
    typedef struct {
        logic [15:0] id;
        logic [15:0] addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        int nb;
        logic [3:0] strb;
        logic [1:0] exp;
    } vec_t;
    logic aclk = 1'b0;
    logic areset = 1'b1;
`ifdef AXI4_SLV_BRESP_DELAY_EN
    logic [3:0] bdelay = 4'd0;
`endif
    logic [11:0] test_addr = '0;
    logic [7:0] test_data;
    int checks = 0;
    int errors = 0;
    logic [7:0] mem_m [4096];
    logic [31:0] bd [$];
    logic [3:0] bs [$];
    vec_t tbl [14];
    axi4_slave_write_responder_if bus ();
    axi4_slave_write_responder dut (
        .aclk(aclk),
        .areset(areset),
`ifdef AXI4_SLV_BRESP_DELAY_EN
        .bdelay(bdelay),
`endif
        .bus(bus),
        .test_addr(test_addr),
        .test_data(test_data)
    );
    always #5 aclk = ~aclk;
    initial begin
        #900000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: walk beat addresses with plain arithmetic, apply strobes, derive the response.
    function automatic logic [1:0] model(input logic [15:0] addr, input logic [7:0] len,
                                         input logic [2:0] size, input logic [1:0] burst, input int nb);
        int sz = 1 << size;
        int a = int'(addr);
        int last;
        bit bad = (burst >= 2) || (sz > 4);
        bit slv = bad || (nb != int'(len) + 1);
        bit dec = 0;
        last = (a / sz) * sz + int'(len) * sz;
        if (burst == 1 && a / 4096 != last / 4096) slv = 1;
        for (int b = 0; b < nb; b++) begin
            if (b > int'(len)) continue;
            if (a >= 4096) dec = 1;
            else if (!bad)
                for (int i = 0; i < 4; i++) if (bs[b][i]) mem_m[(a / 4) * 4 + i] = bd[b][8*i +: 8];
            if (burst == 1) a = ((a / sz) * sz + sz) % 65536;
        end
        return dec ? 2'b11 : slv ? 2'b10 : 2'b00;
    endfunction

    task automatic read_word(input int a, output logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            test_addr = 12'(a + i);
            #1;
            w[8*i +: 8] = test_data;
        end
    endtask

    task automatic mem_check(input string name);
        int bad = 0;
        int first = 0;
        logic [7:0] got = '0;
        for (int i = 0; i < 4096; i++) begin
            test_addr = 12'(i);
            #1;
            if (test_data !== mem_m[i]) begin
                if (bad == 0) begin
                    first = i;
                    got = test_data;
                end
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s mem: %0d bytes differ, first at %0h got %0h expected %0h",
                     name, bad, first, got, mem_m[first]);
        end
    endtask

    task automatic run_burst(input string name, input logic [15:0] id, input logic [15:0] addr,
                             input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                             input logic [1:0] exp, input int hold, input int gaps, input logic [3:0] dly);
        int n;
        int exp_lat;
        bit stable;
        logic [15:0] id0;
        logic [1:0] r0;
`ifdef AXI4_SLV_BRESP_DELAY_EN
        bdelay = dly;
        exp_lat = int'(dly) + 1;
`else
        exp_lat = 1;
`endif
        bus.awid = id;
        bus.awaddr = addr;
        bus.awlen = len;
        bus.awsize = size;
        bus.awburst = burst;
        bus.awvalid = 1'b1;
        n = 0;
        while (!bus.awready && n < 50) begin
            tick();
            n++;
        end
        if (!bus.awready) begin
            bus.awvalid = 1'b0;
            check({name, " aw timeout"}, n, 0);
            return;
        end
        tick();
        bus.awvalid = 1'b0;
        check({name, " awready busy"}, bus.awready, 1'b0);
        for (int b = 0; b < bd.size(); b++) begin
            repeat ($urandom_range(0, gaps)) tick();
            bus.wdata = bd[b];
            bus.wstrb = bs[b];
            bus.wlast = (b == bd.size() - 1);
            bus.wvalid = 1'b1;
            n = 0;
            while (!bus.wready && n < 50) begin
                tick();
                n++;
            end
            if (!bus.wready) begin
                bus.wvalid = 1'b0;
                check({name, " w timeout"}, n, 0);
                return;
            end
            tick();
            bus.wvalid = 1'b0;
            bus.wlast = 1'b0;
        end
        n = 1;
        while (!bus.bvalid && n < 60) begin
            tick();
            n++;
        end
        check({name, " b latency"}, n, exp_lat);
        if (!bus.bvalid) return;
        check({name, " bid"}, bus.bid, id);
        check({name, " bresp"}, bus.bresp, exp);
        id0 = bus.bid;
        r0 = bus.bresp;
        stable = 1;
        repeat (hold) begin
            tick();
            if (!bus.bvalid || bus.bid !== id0 || bus.bresp !== r0) stable = 0;
        end
        if (hold > 0) check({name, " b stable"}, stable, 1'b1);
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        check({name, " awready after b"}, bus.awready, 1'b1);
    endtask

    initial begin
        logic [31:0] w;
        logic [1:0] exp;
        logic [15:0] id, addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        int nb, r;
        bit seen;
        tbl[0]  = '{16'd5,     16'h0010, 8'd3, 3'd2, 2'b01, 4, 4'hF, 2'b00};
        tbl[1]  = '{16'd7,     16'h0040, 8'd3, 3'd2, 2'b01, 2, 4'hF, 2'b10};
        tbl[2]  = '{16'd2,     16'h2000, 8'd0, 3'd2, 2'b01, 1, 4'hF, 2'b11};
        tbl[3]  = '{16'd3,     16'h0080, 8'd1, 3'd2, 2'b10, 2, 4'hF, 2'b10};
        tbl[4]  = '{16'd4,     16'h0090, 8'd0, 3'd3, 2'b01, 1, 4'hF, 2'b10};
        tbl[5]  = '{16'd9,     16'h0FF8, 8'd3, 3'd2, 2'b01, 4, 4'hF, 2'b11};
        tbl[6]  = '{16'd6,     16'h0100, 8'd1, 3'd2, 2'b01, 3, 4'hF, 2'b10};
        tbl[7]  = '{16'd8,     16'h0201, 8'd2, 3'd0, 2'b01, 3, 4'hF, 2'b00};
        tbl[8]  = '{16'd10,    16'h0300, 8'd2, 3'd2, 2'b00, 3, 4'h5, 2'b00};
        tbl[9]  = '{16'd11,    16'h0FFC, 8'd0, 3'd2, 2'b01, 1, 4'hF, 2'b00};
        tbl[10] = '{16'd12,    16'h1000, 8'd0, 3'd2, 2'b00, 1, 4'hF, 2'b11};
        tbl[11] = '{16'd13,    16'h0400, 8'd0, 3'd2, 2'b11, 1, 4'hF, 2'b10};
        tbl[12] = '{16'd14,    16'h3000, 8'd0, 3'd2, 2'b10, 1, 4'hF, 2'b11};
        tbl[13] = '{16'hBEEF,  16'hFFFC, 8'd1, 3'd2, 2'b01, 2, 4'hF, 2'b11};
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
        bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b0;
        repeat (3) tick();
        check("rst awready", bus.awready, 1'b0);
        check("rst wready", bus.wready, 1'b0);
        check("rst bvalid", bus.bvalid, 1'b0);
        check("rst bid", bus.bid, 16'd0);
        check("rst bresp", bus.bresp, 2'b00);
        areset = 1'b0;
        #1;
        check("post-rst awready", bus.awready, 1'b1);
        bus.wvalid = 1'b1;
        tick();
        check("idle w stalled", bus.wready, 1'b0);
        bus.wvalid = 1'b0;
        // Fill the whole memory so every byte is known to the model.
        for (int k = 0; k < 4; k++) begin
            bd.delete();
            bs.delete();
            for (int b = 0; b < 256; b++) begin
                bd.push_back($urandom);
                bs.push_back(4'hF);
            end
            exp = model(16'(k * 1024), 8'd255, 3'd2, 2'b01, 256);
            run_burst("init", 16'(k), 16'(k * 1024), 8'd255, 3'd2, 2'b01, exp, 0, 0, 4'd0);
        end
        mem_check("init");
        for (int v = 0; v < 14; v++) begin
            bd.delete();
            bs.delete();
            for (int b = 0; b < tbl[v].nb; b++) begin
                bd.push_back((b + 1) * 32'h11111111);
                bs.push_back(tbl[v].strb);
            end
            void'(model(tbl[v].addr, tbl[v].len, tbl[v].size, tbl[v].burst, tbl[v].nb));
            run_burst($sformatf("vec%0d", v), tbl[v].id, tbl[v].addr, tbl[v].len, tbl[v].size,
                      tbl[v].burst, tbl[v].exp, v == 0 ? 5 : v % 3, 1, 4'(v % 4));
            mem_check($sformatf("vec%0d", v));
        end
        read_word(16'h10, w);
        check("incr word 0x10", w, 32'h11111111);
        read_word(16'h1C, w);
        check("incr word 0x1C", w, 32'h44444444);
        bd = '{32'hAAAA1234, 32'h5678BBBB};
        bs = '{4'h3, 4'hC};
        void'(model(16'h0020, 8'd1, 3'd2, 2'b00, 2));
        run_burst("fixed", 16'h21, 16'h0020, 8'd1, 3'd2, 2'b00, 2'b00, 0, 0, 4'd3);
        read_word(16'h20, w);
        check("fixed word 0x20", w, 32'h56781234);
        // Reset mid-burst: one beat lands, then no response may appear.
        bus.awid = 16'h77; bus.awaddr = 16'h0500; bus.awlen = 8'd3; bus.awsize = 3'd2;
        bus.awburst = 2'b01; bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        bus.wdata = 32'hCAFEF00D; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        {mem_m[16'h503], mem_m[16'h502], mem_m[16'h501], mem_m[16'h500]} = 32'hCAFEF00D;
        areset = 1'b1;
        tick();
        check("mid rst awready", bus.awready, 1'b0);
        check("mid rst wready", bus.wready, 1'b0);
        check("mid rst bvalid", bus.bvalid, 1'b0);
        tick();
        areset = 1'b0;
        #1;
        check("mid rst release awready", bus.awready, 1'b1);
        seen = 0;
        bus.wvalid = 1'b1;
        repeat (8) begin
            tick();
            if (bus.bvalid || bus.wready) seen = 1;
        end
        bus.wvalid = 1'b0;
        check("mid rst no b/w", seen, 1'b0);
        mem_check("mid rst");
        for (int t = 0; t < 40; t++) begin
            id = 16'($urandom);
            size = $urandom_range(0, 9) == 0 ? 3'd3 : 3'($urandom_range(0, 2));
            burst = $urandom_range(0, 9) == 0 ? 2'b10 : 2'($urandom_range(0, 1));
            len = 8'($urandom_range(0, 7));
            addr = 16'($urandom_range(0, 16'h10FF));
            r = $urandom_range(0, 9);
            nb = r == 0 ? int'(len) + 2 : (r == 1 && len > 0) ? $urandom_range(1, int'(len)) : int'(len) + 1;
            bd.delete();
            bs.delete();
            for (int b = 0; b < nb; b++) begin
                bd.push_back($urandom);
                bs.push_back(4'($urandom));
            end
            exp = model(addr, len, size, burst, nb);
            run_burst($sformatf("rnd%0d", t), id, addr, len, size, burst, exp,
                      $urandom_range(0, 3), 2, 4'($urandom_range(0, 5)));
            mem_check($sformatf("rnd%0d", t));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
